four_way_rr_arbiter: RTL and testbench
======================================

# four_way_rr_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit output channel among four requesters. It drives the select of an internal `four_to_one_mux` and registers the chosen operand. It presents the result downstream with a valid/ready handshake and acknowledges the winning requester on transfer. It sits between the processor's four operand/write-back sources and the shared consumer port, replacing hard-wired SEL generation.

## Interface
- WIDTH, 8, data width of each requester and of the output
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset (assert async, deassert synchronously to clk upstream)
- req  input  4  request per source; bit i = source i (A=0, B=1, C=2, D=3)
- data_a / data_b / data_c / data_d  input  WIDTH each  source operands; must stay stable while the matching req is high
- ack  output  4  one-hot; ack[i] high in the cycle source i's data is accepted downstream
- sel  output  2  current grant index; also drives the internal mux SEL
- out_valid  output  1  out_data holds a granted transfer
- out_data  output  WIDTH  registered payload
- out_ready  input  1  downstream accepts when out_valid & out_ready

## Operation
- State machine, 2 states:
  - IDLE: out_valid=0. If req != 0, pick a winner, latch sel, capture the mux output into out_data, and go to BUSY.
  - BUSY: out_valid=1. Hold sel and out_data stable while out_ready=0.
    - On out_valid & out_ready: ack[sel]=1 (combinational, same cycle) and ptr <= sel+1 (mod 4).
    - Then re-arbitrate in the same cycle over req & ~(1<<sel). If a candidate exists, stay in BUSY with the new sel and out_data; otherwise go to IDLE.
- Arbitration: the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). ptr resets to 0.
- The next-sel value is combinational and feeds the mux, so the captured data matches the winner.
- Requesters must drop req the cycle after ack unless they have a new item. A req still high one cycle after its ack counts as a new request.
- A req withdrawn while BUSY does not cancel the grant; the transfer completes.
- Reset (any time, including mid-transfer): state=IDLE, out_valid=0, out_data=0, sel=0, ptr=0, ack=0. The in-flight transfer is dropped and not acked.

## Timing
- Latency: req rising at edge N → out_valid=1 after edge N+1 (1 cycle), when the arbiter is IDLE.
- Throughput: 1 transfer per cycle under continuous out_ready with ≥2 distinct requesters active.
- A single requester re-requesting alternates BUSY/IDLE, giving 1 transfer per 2 cycles. This is intended, because of the self-exclusion rule.
- out_data and sel change only on the arbitration edge. Both are stable from out_valid rise until acceptance.
- ack is never asserted while out_valid=0, and at most one bit is set.
- Simultaneous acceptance and new requests are resolved with the post-update ptr: winner search starts at the old sel+1.

## Structure
- Shared package (proc_pkg): SRC_A=2'd0, SRC_B=2'd1, SRC_C=2'd2, SRC_D=2'd3, plus the state encoding (ARB_IDLE, ARB_BUSY).
- One sub-module: the existing `four_to_one_mux` (WIDTH passed through), instantiated for the data path and driven by next-sel.
- Winner search is a local function (rotate, priority-encode, rotate back); it does not need a separate module.

## Test plan
- Reset mid-BUSY: req=4'b0001, reset_n pulsed low while out_valid=1 → out_valid=0, out_data=0, sel=0, ack=0 immediately; no ack ever issued for that item.
- Single request: req=4'b0100, data_c=8'h5A, out_ready=1 → out_valid after 1 cycle, out_data=8'h5A, sel=2, ack=4'b0100 that cycle, then IDLE.
- Round robin: req=4'b1111 held, out_ready=1 → sel sequence 0,1,2,3,0 on consecutive cycles with one ack per cycle and out_data tracking data_a..data_d.
- Backpressure: req=4'b0011, out_ready=0 for 5 cycles → sel=0, out_data=data_a held stable, ack=0. When out_ready=1, ack=4'b0001 and next cycle sel=1.
- Fairness after ptr move: grant D (ptr→0), then req=4'b1010 → B granted before D.
- Single-source streaming: req[0] held high, out_ready=1 → acks on alternating cycles, never back-to-back.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - source indices and arbiter state encoding shared by the operand path
package proc_pkg;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/four_to_one_mux.sv
// rtl/four_to_one_mux.sv - WIDTH-bit four-input select mux
module four_to_one_mux
  import proc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (sel_i)
      SRC_A:   y_o = a_i;
      SRC_B:   y_o = b_i;
      SRC_C:   y_o = c_i;
      SRC_D:   y_o = d_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/four_way_rr_arbiter.sv
// rtl/four_way_rr_arbiter.sv - round-robin arbiter sharing one output channel among four sources
module four_way_rr_arbiter
  import proc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  arb_state_e       state_q;
  logic [1:0]       sel_q;
  logic [1:0]       ptr_q;
  logic [WIDTH-1:0] data_q;

  logic             accept;
  logic [3:0]       cand;
  logic [1:0]       base;
  logic [2:0]       pick;
  logic [1:0]       mux_sel;
  logic [WIDTH-1:0] mux_out;

  // Returns {found, index}: first set bit of r scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] enc;
    dbl = {r, r};
    rot = dbl[p +: 4];
    enc = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) enc = 2'(i);
    end
    return {|rot, enc + p};
  endfunction

  // On acceptance the current winner is excluded and the search starts just past it.
  always_comb begin
    accept = (state_q == ARB_BUSY) && out_ready;
    cand   = 4'b0000;
    base   = ptr_q;
    if (state_q == ARB_IDLE) begin
      cand = req;
    end else if (accept) begin
      cand = req & ~(4'b0001 << sel_q);
      base = sel_q + 2'd1;
    end
    pick    = rr_pick(cand, base);
    mux_sel = pick[2] ? pick[1:0] : sel_q;
    ack     = accept ? (4'b0001 << sel_q) : 4'b0000;
  end

  four_to_one_mux #(.WIDTH(WIDTH)) u_mux (
    .sel_i (mux_sel),
    .a_i   (data_a),
    .b_i   (data_b),
    .c_i   (data_c),
    .d_i   (data_d),
    .y_o   (mux_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      sel_q   <= SRC_A;
      ptr_q   <= SRC_A;
      data_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick[2]) begin
            state_q <= ARB_BUSY;
            sel_q   <= pick[1:0];
            data_q  <= mux_out;
          end
        end
        ARB_BUSY: begin
          if (accept) begin
            ptr_q <= sel_q + 2'd1;
            if (pick[2]) begin
              sel_q  <= pick[1:0];
              data_q <= mux_out;
            end else begin
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign out_valid = (state_q == ARB_BUSY);
  assign out_data  = data_q;

endmodule

// File: tb/tb_four_way_rr_arbiter.sv
// tb/tb_four_way_rr_arbiter.sv - directed self-checking bench for four_way_rr_arbiter
module tb_four_way_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [7:0] data_a = 8'h00, data_b = 8'h00, data_c = 8'h00, data_d = 8'h00;
  logic [3:0] ack;
  logic [1:0] sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  four_way_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .data_d    (data_d),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    out_ready = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_data !== 8'h00) $display("FAIL reset_data got %h exp 00", out_data); else pass_cnt++;
    total_cnt++;
    if (sel !== 2'd0) $display("FAIL reset_sel got %0d exp 0", sel); else pass_cnt++;
    total_cnt++;
    if (ack !== 4'b0000) $display("FAIL reset_ack got %b exp 0000", ack); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    data_c = 8'h5A;
    req = 4'b0100;
    out_ready = 1'b1;
    step();
    #1;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL single_valid got %0b exp 1", out_valid); else pass_cnt++;
    total_cnt++;
    if (out_data !== 8'h5A) $display("FAIL single_data got %h exp 5a", out_data); else pass_cnt++;
    total_cnt++;
    if (sel !== 2'd2) $display("FAIL single_sel got %0d exp 2", sel); else pass_cnt++;
    total_cnt++;
    if (ack !== 4'b0100) $display("FAIL single_ack got %b exp 0100", ack); else pass_cnt++;
    req = 4'b0000;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || ack !== 4'b0000)
      $display("FAIL single_idle got valid=%0b ack=%b exp valid=0 ack=0000", out_valid, ack);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
    do_reset();
    data_a = 8'h11; data_b = 8'h22; data_c = 8'h33; data_d = 8'h44;
    req = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total_cnt++;
      if (sel !== 2'(k % 4) || out_data !== exp_data[k % 4] || ack !== (4'b0001 << (k % 4)) || out_valid !== 1'b1)
        $display("FAIL rr_cycle%0d got sel=%0d data=%h ack=%b valid=%0b exp sel=%0d data=%h ack=%b valid=1",
                 k, sel, out_data, ack, out_valid, k % 4, exp_data[k % 4], 4'b0001 << (k % 4));
      else pass_cnt++;
    end
    req = 4'b0000;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rr_drain got valid=%0b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    data_a = 8'hA1; data_b = 8'hB2;
    req = 4'b0011;
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (sel !== 2'd0 || out_data !== 8'hA1 || ack !== 4'b0000 || out_valid !== 1'b1)
        $display("FAIL bp_hold%0d got sel=%0d data=%h ack=%b valid=%0b exp sel=0 data=a1 ack=0000 valid=1",
                 k, sel, out_data, ack, out_valid);
      else pass_cnt++;
      if (k < 4) step();
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (ack !== 4'b0001) $display("FAIL bp_ack_a got %b exp 0001", ack); else pass_cnt++;
    step();
    req = 4'b0010;
    #1;
    total_cnt++;
    if (sel !== 2'd1 || out_data !== 8'hB2 || ack !== 4'b0010)
      $display("FAIL bp_next_b got sel=%0d data=%h ack=%b exp sel=1 data=b2 ack=0010", sel, out_data, ack);
    else pass_cnt++;
    req = 4'b0000;
    step();
  endtask

  task automatic test_fairness();
    do_reset();
    data_b = 8'hB5; data_d = 8'hD4;
    req = 4'b1000;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (sel !== 2'd3 || ack !== 4'b1000) $display("FAIL fair_d_first got sel=%0d ack=%b exp sel=3 ack=1000", sel, ack); else pass_cnt++;
    req = 4'b0000;
    step();
    req = 4'b1010;
    step();
    total_cnt++;
    if (sel !== 2'd1 || out_data !== 8'hB5 || ack !== 4'b0010)
      $display("FAIL fair_b_before_d got sel=%0d data=%h ack=%b exp sel=1 data=b5 ack=0010", sel, out_data, ack);
    else pass_cnt++;
    step();
    req = 4'b1000;
    #1;
    total_cnt++;
    if (sel !== 2'd3 || out_data !== 8'hD4 || ack !== 4'b1000)
      $display("FAIL fair_d_after got sel=%0d data=%h ack=%b exp sel=3 data=d4 ack=1000", sel, out_data, ack);
    else pass_cnt++;
    req = 4'b0000;
    step();
  endtask

  task automatic test_streaming();
    int acks;
    acks = 0;
    do_reset();
    data_a = 8'h77;
    req = 4'b0001;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ack[0]) acks++;
      total_cnt++;
      if (ack !== ((k % 2 == 0) ? 4'b0001 : 4'b0000) || out_valid !== (k % 2 == 0))
        $display("FAIL stream_cycle%0d got ack=%b valid=%0b exp ack=%b valid=%0b",
                 k, ack, out_valid, (k % 2 == 0) ? 4'b0001 : 4'b0000, k % 2 == 0);
      else pass_cnt++;
    end
    total_cnt++;
    if (acks != 4) $display("FAIL stream_count got %0d exp 4", acks); else pass_cnt++;
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_busy();
    int acks;
    acks = 0;
    do_reset();
    data_a = 8'h5C;
    req = 4'b0001;
    out_ready = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'h5C) $display("FAIL rmb_busy got valid=%0b data=%h exp valid=1 data=5c", out_valid, out_data); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 2'd0 || ack !== 4'b0000)
      $display("FAIL rmb_async got valid=%0b data=%h sel=%0d ack=%b exp valid=0 data=00 sel=0 ack=0000",
               out_valid, out_data, sel, ack);
    else pass_cnt++;
    req = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (ack != 4'b0000) acks++;
    end
    total_cnt++;
    if (acks != 0) $display("FAIL rmb_no_ack got %0d acks exp 0", acks); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_streaming();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
